// File: rtl/range_pkg.sv
// Shared types and constants for the go/finish/data range stream generator.
package range_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    localparam int unsigned MIN_LEN = 2;
    localparam int unsigned TAP_W   = 16;

    // Galois LFSR tap masks for the supported sample widths.
    function automatic logic [TAP_W-1:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 16'h00B8;
            10:      return 16'h0240;
            12:      return 16'h0E08;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/range_lfsr.sv
// Galois LFSR sample register; clears to zero between bursts so it can drive data directly.
module range_lfsr #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             clear,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q
);
    import range_pkg::*;

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] q_n;

    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    always_comb begin
        q_n = q;
        if (clear) begin
            q_n = '0;
        end else if (load) begin
            q_n = (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            q_n = (q >> 1) ^ (q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_n;
        end
    end

endmodule

// File: rtl/range_stream_gen.sv
// Burst generator for the range-finder stream: framed LFSR samples plus the expected max-min range.
module range_stream_gen #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             go,
    output logic             finish,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] exp_range,
    output logic             exp_valid,
    output logic             cfg_error
);
    import range_pkg::*;

    gen_state_t       state_q, state_n;
    logic [LEN_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] max_q, max_n, min_q, min_n;
    logic [WIDTH-1:0] run_max, run_min, range_n;
    logic [WIDTH-1:0] sample;
    logic             busy_n, go_n, finish_n, exp_valid_n, cfg_error_n;
    logic             lfsr_load, lfsr_step, lfsr_clear;

    range_lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .clear (lfsr_clear),
        .seed  (seed),
        .q     (sample)
    );

    // The LFSR register is itself the registered sample output.
    assign data_out = sample;

    // cnt_q counts samples remaining including the one currently presented.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        max_n       = max_q;
        min_n       = min_q;
        range_n     = exp_range;
        busy_n      = 1'b0;
        go_n        = 1'b0;
        finish_n    = 1'b0;
        exp_valid_n = 1'b0;
        cfg_error_n = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        lfsr_clear  = 1'b0;

        run_max = go ? sample : ((sample > max_q) ? sample : max_q);
        run_min = go ? sample : ((sample < min_q) ? sample : min_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len >= LEN_W'(MIN_LEN)) begin
                        lfsr_load = 1'b1;
                        cnt_n     = len;
                        go_n      = 1'b1;
                        busy_n    = 1'b1;
                        state_n   = SEND;
                    end else begin
                        cfg_error_n = 1'b1;
                    end
                end
            end
            SEND: begin
                max_n = run_max;
                min_n = run_min;
                if (cnt_q > LEN_W'(1)) begin
                    lfsr_step = 1'b1;
                    cnt_n     = cnt_q - LEN_W'(1);
                    busy_n    = 1'b1;
                    finish_n  = (cnt_q == LEN_W'(2));
                end else begin
                    lfsr_clear  = 1'b1;
                    exp_valid_n = 1'b1;
                    range_n     = run_max - run_min;
                    state_n     = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            busy      <= 1'b0;
            go        <= 1'b0;
            finish    <= 1'b0;
            exp_range <= '0;
            exp_valid <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            max_q     <= max_n;
            min_q     <= min_n;
            busy      <= busy_n;
            go        <= go_n;
            finish    <= finish_n;
            exp_range <= range_n;
            exp_valid <= exp_valid_n;
            cfg_error <= cfg_error_n;
        end
    end

endmodule

// File: doc/range_stream_gen.md
# range_stream_gen

Transmit-side driver for the go/finish/data range-finder stream protocol. On a start request it emits a burst of pseudo-random WIDTH-bit samples, framed by a one-cycle `go` on the first sample and a one-cycle `finish` on the last. Its own running max/min gives the expected range, so the block can drive a range finder on-chip and both results can be checked against each other.

## Interface
- `WIDTH`, 10, sample width. Legal values: 8, 10, 12. Each has a tap constant in the package.
- `LEN_W`, 8, width of the burst-length field.
- `clock` in 1: sole clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a burst; sampled only in IDLE.
- `seed` in WIDTH: LFSR seed, latched on accepted start.
- `len` in LEN_W: number of samples in the burst, latched on accepted start.
- `busy` out 1: high from the cycle after an accepted start until the cycle after the last sample.
- `go` out 1: high exactly on the first sample cycle.
- `finish` out 1: high exactly on the last sample cycle.
- `data_out` out WIDTH: sample; valid every cycle from `go` to `finish` inclusive; 0 otherwise.
- `exp_range` out WIDTH: max−min of the last burst; holds until the next burst completes.
- `exp_valid` out 1: one-cycle pulse when `exp_range` updates.
- `cfg_error` out 1: one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, SEND, DONE.
- **IDLE, start=1, len≥2:**
  - Latch `seed`; a zero seed is replaced by 1.
  - Load the counter with `len`.
  - Go to SEND.
- **IDLE, start=1, len<2:**
  - Pulse `cfg_error` next cycle.
  - Stay in IDLE; no framing outputs.
- **SEND, sample generation:**
  - Sample k=1 is the latched seed.
  - Each later sample is the next state of a Galois LFSR: shift right one bit; if the shifted-out LSB was 1, XOR the tap mask.
  - WIDTH=10 mask = 10'h240.
- **SEND, framing:**
  - `go` on k=1; `finish` on k=len.
  - Counter decrements each sample. After k=len, go to DONE.
- **SEND, max/min tracking:**
  - On k=1, max and min both load the sample.
  - On later samples, unsigned compare against each.
- **DONE:**
  - `exp_range` ← max−min, unsigned, WIDTH bits, never negative.
  - `exp_valid`=1; `busy`=0.
  - Return to IDLE.
- `start` in SEND or DONE is ignored. It is not queued and does not raise `cfg_error`.
- len=2^LEN_W−1 is legal; the counter must not wrap early.
- **Reset:** at any time, including mid-burst, the next edge forces IDLE.
  - All outputs go to 0; `exp_range`=0.
  - No `finish` or `exp_valid` is emitted for the aborted burst.

## Timing
- Start accepted at edge t. `go`+sample 1 are visible in cycle t+1 through cycle t+len. `finish` is visible in cycle t+len. `exp_valid` is visible in cycle t+len+1.
- All outputs are registered; there is no combinational path from inputs.
- A new start is accepted in the `exp_valid` cycle's following IDLE cycle at the earliest. Minimum gap between bursts is 2 cycles (DONE, then IDLE).
- `go` and `finish` are never high in the same cycle.

## Structure
- Package `range_pkg`:
  - state enum `gen_state_t` {IDLE, SEND, DONE};
  - function `lfsr_taps(width)` returning masks for 8 (8'hB8), 10 (10'h240), 12 (12'hE08);
  - constant `MIN_LEN`=2.
- Sub-module `range_lfsr`, parameter WIDTH. Ports: `load`, `seed`, `step`, `q`. Holds the LFSR register and applies the zero-seed substitution.
- The top holds the FSM, counter, max/min registers and output registers.

## Test plan
- seed=1, len=2, WIDTH=10 -> cycle t+1: go=1, data=1. Cycle t+2: finish=1, data=576. Cycle t+3: exp_valid=1, exp_range=575.
- seed=0, len=2 -> identical output to seed=1 (1, 576; range 575).
- len=1 and len=0 -> cfg_error pulses for one cycle; go/finish/busy stay 0.
- seed=10'h155, len=255 -> 255 samples match the software LFSR model. Exactly one go and one finish. exp_range equals model max−min.
- start held high throughout a len=5 burst -> exactly one burst. Next burst's go appears 2 cycles after exp_valid.
- reset asserted on sample 3 of a len=10 burst -> next cycle all outputs 0, no finish, no exp_valid. A fresh start then behaves normally.
